rom_port_arbiter: RTL and testbench

//  Shares one external memory read port between NUM_REQ emulated ROM/EPROM requesters
//  (e.g. tile EPROMs 4R/4S/7R/7S), so a single FPGA memory backs all of them.

---
 rtl/rom_port_arbiter_pkg.sv | 16 +
 rtl/rom_port_arbiter_rr_picker.sv | 29 ++
 rtl/rom_port_arbiter.sv | 137 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared types for the ROM port arbiter: FSM state encoding and watchdog width.
package rom_port_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIT   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Watchdog counter width; covers TIMEOUT values up to 255
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/rom_port_arbiter_rr_picker.sv
// Round-robin picker: first requester with req set, searching upward from ptr+1
// and wrapping, so the requester at ptr itself has the lowest priority.
module rom_port_arbiter_rr_picker #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [SEL_WIDTH-1:0] ptr_i,
    output logic                 any_o,
    output logic [SEL_WIDTH-1:0] idx_o
);

    logic [SEL_WIDTH-1:0] cand;

    // Walk the rotated order from farthest to nearest so the nearest hit wins
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = SEL_WIDTH'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one memory read port between NUM_REQ ROM requesters with round-robin
// grant, a one-entry last-address cache per requester and a per-access watchdog.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2,
    parameter int TIMEOUT    = 63
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0]   rdata_o,
    input  logic                            cache_inv_i,
    output logic                            mem_req_o,
    output logic [SEL_WIDTH+ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                            mem_ack_i,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
    output logic                            timeout_err_o
);

    localparam logic [DATA_WIDTH-1:0] ERASED_DATA = {DATA_WIDTH{1'b1}};
    localparam logic [TMO_CNT_W-1:0]  CNT_LAST    = TMO_CNT_W'(TIMEOUT - 1);

    state_e                                 state_q, state_d;
    logic [SEL_WIDTH-1:0]                   sel_q, rr_ptr_q;
    logic [SEL_WIDTH+ADDR_WIDTH-1:0]        mem_addr_q;
    logic [TMO_CNT_W-1:0]                   cnt_q;
    logic [NUM_REQ-1:0]                     ack_q;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     rdata_q;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     tag_q;
    logic [NUM_REQ-1:0]                     valid_q;
    logic                                   tmo_err_q;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_v;
    logic                                   pick_any, pick_go, pick_hit;
    logic [SEL_WIDTH-1:0]                   pick_idx;
    logic                                   wait_fill, wait_tmo;

    assign addr_v = addr_i;

    rom_port_arbiter_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_picker (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // A hit's ack lands in an IDLE cycle while the requester still holds req;
    // holding off the pick during any ack cycle stops that req being served twice.
    assign pick_go  = (state_q == ST_IDLE) && pick_any && (ack_q == '0);
    assign pick_hit = valid_q[pick_idx] && (tag_q[pick_idx] == addr_v[pick_idx]);

    // Next-state logic; flags the two ways a WAIT access can end
    always_comb begin
        state_d   = state_q;
        wait_fill = 1'b0;
        wait_tmo  = 1'b0;
        case (state_q)
            ST_IDLE:  if (pick_go) state_d = pick_hit ? ST_HIT : ST_ISSUE;
            ST_HIT:   state_d = ST_IDLE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack_i) begin
                    wait_fill = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    wait_tmo  = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Grant bookkeeping, watchdog, cache fill/invalidate and read-data holding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q      <= '0;
            rr_ptr_q   <= SEL_WIDTH'(NUM_REQ - 1);
            mem_addr_q <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            tag_q      <= '0;
            valid_q    <= '0;
            tmo_err_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            if (pick_go) begin
                sel_q    <= pick_idx;
                rr_ptr_q <= pick_idx;
                // Address is captured once here; later addr_i changes are ignored
                if (!pick_hit) mem_addr_q <= {pick_idx, addr_v[pick_idx]};
            end
            // Hit data is already sitting in rdata_q from the fill that set the tag
            if (state_q == ST_HIT) ack_q[sel_q] <= 1'b1;
            if (state_q == ST_ISSUE)     cnt_q <= '0;
            else if (state_q == ST_WAIT) cnt_q <= cnt_q + TMO_CNT_W'(1);
            if (wait_fill) begin
                rdata_q[sel_q] <= mem_rdata_i;
                tag_q[sel_q]   <= mem_addr_q[ADDR_WIDTH-1:0];
                valid_q[sel_q] <= 1'b1;
                ack_q[sel_q]   <= 1'b1;
            end
            if (wait_tmo) begin
                rdata_q[sel_q] <= ERASED_DATA;
                valid_q[sel_q] <= 1'b0;
                tmo_err_q      <= 1'b1;
                ack_q[sel_q]   <= 1'b1;
            end
            // Invalidate last so it overrides a fill in the same cycle
            if (cache_inv_i) valid_q <= '0;
        end
    end

    assign mem_req_o     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mem_addr_o    = mem_addr_q;
    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign timeout_err_o = tmo_err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: expected acks are queued as requests are
// driven and compared, in order, whenever the DUT pulses ack.
module tb_rom_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req;
    logic [NR*AW-1:0]    addr;
    logic [NR-1:0]       ack;
    logic [NR*DW-1:0]    rdata;
    logic                cache_inv;
    logic                mem_req;
    logic [SW+AW-1:0]    mem_addr;
    logic                mem_ack;
    logic [DW-1:0]       mem_rdata;
    logic                timeout_err;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    // memory model controls and statistics
    bit          mem_en = 1'b1;
    int          mem_lat = 1;
    logic        man_ack = 1'b0;
    logic [7:0]  man_data = 8'h00;
    int          mem_acc = 0;
    int          mem_req_cyc = 0;
    logic        mreq_prev = 1'b0;
    logic [17:0] last_mem_addr = '0;

    rom_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .addr_i        (addr),
        .ack_o         (ack),
        .rdata_o       (rdata),
        .cache_inv_i   (cache_inv),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .timeout_err_o (timeout_err)
    );

    always #5 clk = ~clk;

    // Memory contents: address hash chosen so {1,16'h1234} reads 8'hA5
    function automatic logic [7:0] memf(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h82;
    endfunction

    // Memory side: auto mode acks mem_lat cycles into WAIT, manual mode forwards man_ack
    initial begin : mem_model
        int k;
        k = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_req && !mreq_prev) mem_acc++;
            if (mem_req) mem_req_cyc++;
            mreq_prev = mem_req;
            if (mem_en) begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    k++;
                    if (k == mem_lat + 1) begin
                        mem_ack = 1'b1;
                        mem_rdata = memf(mem_addr);
                        last_mem_addr = mem_addr;
                    end
                end else begin
                    k = 0;
                end
            end else begin
                k = 0;
                mem_ack = man_ack;
                mem_rdata = man_data;
            end
        end
    end

    // Scoreboard: every ack must be one-hot and match the oldest expected entry
    always @(negedge clk) begin
        if (ack !== '0) begin
            checks++;
            if ($countones(ack) != 1) begin
                errors++;
                $display("FAIL ack_onehot: ack=%b, required exactly one bit", ack);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=%b, required no ack", ack);
            end else begin
                mon_e = exp_q.pop_front();
                if (ack[mon_e.idx] !== 1'b1 || rdata[mon_e.idx*DW +: DW] !== mon_e.data) begin
                    errors++;
                    $display("FAIL ack_data: ack=%b rdata=%h, required requester %0d data %h",
                             ack, rdata, mon_e.idx, mon_e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from requester i; expectation queued, req dropped on ack
    task automatic serve(input int i, input logic [15:0] a, input logic [7:0] d, output int cyc);
        exp_t x;
        bit   got;
        @(negedge clk);
        x.idx = i;
        x.data = d;
        exp_q.push_back(x);
        req[i] = 1'b1;
        addr[i*AW +: AW] = a;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack[i] === 1'b1) got = 1'b1;
        end
        req[i] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL serve_no_ack: requester %0d got no ack within %0d cycles", i, cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        addr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        cache_inv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b, required 0", ack); end
            checks++;
            if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
            checks++;
            if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
            checks++;
            if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b, required 0", timeout_err); end
            checks++;
            if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single_miss();
        int cyc, a0;
        mem_en = 1'b1;
        mem_lat = 5;
        a0 = mem_acc;
        serve(1, 16'h1234, 8'hA5, cyc);
        checks++;
        if (cyc != 7) begin errors++; $display("FAIL miss_latency: got %0d cycles, required 7", cyc); end
        checks++;
        if (last_mem_addr !== 18'h11234) begin errors++; $display("FAIL miss_mem_addr: got %h, required 11234", last_mem_addr); end
        checks++;
        if (mem_acc - a0 != 1) begin errors++; $display("FAIL miss_accesses: got %0d, required 1", mem_acc - a0); end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata[15:8] !== 8'hA5) begin errors++; $display("FAIL miss_rdata_held: got %h, required a5", rdata[15:8]); end
    endtask

    task automatic test_hit();
        int cyc, a0;
        a0 = mem_acc;
        serve(1, 16'h1234, 8'hA5, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL hit_latency: got %0d cycles, required 2", cyc); end
        checks++;
        if (mem_acc != a0) begin errors++; $display("FAIL hit_no_access: got %0d accesses, required 0", mem_acc - a0); end
        @(negedge clk);
        cache_inv = 1'b1;
        @(negedge clk);
        cache_inv = 1'b0;
        serve(1, 16'h1234, 8'hA5, cyc);
        checks++;
        if (mem_acc - a0 != 1) begin errors++; $display("FAIL inv_refetch: got %0d accesses, required 1", mem_acc - a0); end
        checks++;
        if (cyc != 7) begin errors++; $display("FAIL inv_latency: got %0d cycles, required 7", cyc); end
    endtask

    // Address changed and req dropped right after the pick: original address still served
    task automatic test_hold_addr();
        exp_t x;
        int   n, cyc, a0;
        mem_lat = 3;
        @(negedge clk);
        x.idx = 0;
        x.data = memf({2'd0, 16'h0F0F});
        exp_q.push_back(x);
        req[0] = 1'b1;
        addr[15:0] = 16'h0F0F;
        @(negedge clk);
        req[0] = 1'b0;
        addr[15:0] = 16'hFFFF;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); #2; n++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL drop_req_served: no ack after %0d cycles", n); exp_q.delete(); end
        checks++;
        if (last_mem_addr !== 18'h00F0F) begin errors++; $display("FAIL hold_addr: got %h, required 00f0f", last_mem_addr); end
        a0 = mem_acc;
        serve(0, 16'h0F0F, memf({2'd0, 16'h0F0F}), cyc);
        checks++;
        if (mem_acc != a0 || cyc != 2) begin
            errors++;
            $display("FAIL hold_addr_hit: got %0d accesses %0d cycles, required 0 and 2", mem_acc - a0, cyc);
        end
    endtask

    // cache_inv coinciding with the fill must leave the entry invalid
    task automatic test_inv_fill();
        exp_t x;
        int   n, cyc, a0;
        mem_en = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        x.idx = 3;
        x.data = 8'h3C;
        exp_q.push_back(x);
        req[3] = 1'b1;
        addr[63:48] = 16'h7777;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 20);
        req[3] = 1'b0;
        @(negedge clk);
        man_ack = 1'b1;
        man_data = 8'h3C;
        cache_inv = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        cache_inv = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin @(negedge clk); #2; n++; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL inv_fill_ack: no ack for manual fill"); exp_q.delete(); end
        mem_en = 1'b1;
        a0 = mem_acc;
        serve(3, 16'h7777, memf({2'd3, 16'h7777}), cyc);
        checks++;
        if (mem_acc - a0 != 1) begin errors++; $display("FAIL inv_wins_fill: got %0d accesses, required 1", mem_acc - a0); end
    endtask

    task automatic test_round_robin();
        logic [15:0] aa[NR];
        exp_t        x;
        int          n, a0;
        do_reset();
        mem_en = 1'b1;
        mem_lat = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                aa[i] = 16'h4000 + 16'(i * 16'h0111);
                x.idx = i;
                x.data = memf({2'(i), aa[i]});
                exp_q.push_back(x);
            end
        end
        a0 = mem_acc;
        for (int i = 0; i < NR; i++) addr[i*AW +: AW] = aa[i];
        req = '1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); #2; n++; end
        req = '0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_complete: %0d acks outstanding after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
        checks++;
        if (mem_acc - a0 != NR) begin errors++; $display("FAIL rr_accesses: got %0d, required %0d", mem_acc - a0, NR); end
    endtask

    task automatic test_timeout();
        int cyc, a0, c0;
        mem_en = 1'b0;
        man_ack = 1'b0;
        a0 = mem_acc;
        c0 = mem_req_cyc;
        serve(2, 16'hBEEF, 8'hFF, cyc);
        // ISSUE cycle plus TO cycles of WAIT
        checks++;
        if (mem_req_cyc - c0 != TO + 1) begin errors++; $display("FAIL tmo_req_cycles: got %0d, required %0d", mem_req_cyc - c0, TO + 1); end
        checks++;
        if (cyc != TO + 2) begin errors++; $display("FAIL tmo_latency: got %0d, required %0d", cyc, TO + 2); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set: got %b, required 1", timeout_err); end
        serve(2, 16'hBEEF, 8'hFF, cyc);
        checks++;
        if (mem_acc - a0 != 2) begin errors++; $display("FAIL tmo_rerequest_miss: got %0d accesses, required 2", mem_acc - a0); end
        mem_en = 1'b1;
        mem_lat = 2;
        serve(2, 16'hBEEF, memf({2'd2, 16'hBEEF}), cyc);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b, required 1", timeout_err); end
    endtask

    task automatic test_reset_mid_wait();
        int n, cyc, a0;
        mem_en = 1'b0;
        man_ack = 1'b0;
        @(negedge clk);
        req[2] = 1'b1;
        addr[47:32] = 16'h5555;
        n = 0;
        do begin @(negedge clk); n++; end while (mem_req !== 1'b1 && n < 20);
        req[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_mem_req: got %b, required 0", mem_req); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_wait_tmo_err: got %b, required 0", timeout_err); end
        rst = 1'b0;
        man_ack = 1'b1;
        man_data = 8'h99;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || ack !== '0) begin
                errors++;
                $display("FAIL late_ack_ignored: mem_req=%b ack=%b, required 0 and 0", mem_req, ack);
            end
        end
        mem_en = 1'b1;
        mem_lat = 1;
        a0 = mem_acc;
        serve(2, 16'h5555, memf({2'd2, 16'h5555}), cyc);
        checks++;
        if (mem_acc - a0 != 1 || cyc != 3) begin
            errors++;
            $display("FAIL rst_wait_refetch: got %0d accesses %0d cycles, required 1 and 3", mem_acc - a0, cyc);
        end
        a0 = mem_acc;
        serve(2, 16'hBEEF, memf({2'd2, 16'hBEEF}), cyc);
        checks++;
        if (mem_acc - a0 != 1) begin errors++; $display("FAIL rst_clears_cache: got %0d accesses, required 1", mem_acc - a0); end
    endtask

    initial begin
        req = '0;
        addr = '0;
        cache_inv = 1'b0;
        rst = 1'b1;
        test_reset();
        test_single_miss();
        test_hit();
        test_hold_addr();
        test_inv_fill();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
